gesture_uart_tx: RTL and testbench
==================================

# gesture_uart_tx

Serialises each finalised gesture result from the per-window gesture counter into a short ASCII message on an 8N1 UART line. It sits directly downstream of the counter. It samples `final_number` on the single-cycle `uart_en` pulse and transmits the frame `G:<d>\r\n`. It holds one pending result so a pulse that arrives while a message is still going out is not lost.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: system clock in Hz.
- `BAUD`, default 115_200: line rate.
- `CLKS_PER_BIT`, default `CLK_FREQ/BAUD` (integer division, 434): cycles per bit. Must be ≥ 2.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `uart_en`, in, 1: one-cycle strobe meaning `final_number` is valid this cycle.
- `final_number`, in, 4: gesture value to send.
- `tx`, out, 1: UART line, idle high.
- `busy`, out, 1: high while a message is in flight or a result is pending.
- `overrun_cnt`, out, 8: count of pending results that were overwritten before being sent. Saturates at 255.

## Operation
- **Message format:** five bytes sent in this order:
  - 0x47 ('G')
  - 0x3A (':')
  - digit byte: 0x30+n for n ≤ 9, otherwise 0x3F ('?')
  - 0x0D
  - 0x0A
- **Byte framing:**
  - Start bit is 0.
  - Then 8 data bits, LSB first.
  - Then 1 stop bit of 1.
  - Each bit lasts exactly `CLKS_PER_BIT` cycles.
- **Message FSM** states: `IDLE`, `SEND`, `GAP`.
  - `IDLE`: when `uart_en` is high, latch `final_number` into `cur_num` and go to `SEND` with byte index 0.
  - `SEND`: issue byte[idx] to the byte transmitter and wait for its `done`. If idx==4, go to `GAP`; otherwise increment idx.
  - `GAP`: lasts one cycle. If `pend_v`, load `cur_num` from `pend_num`, clear `pend_v`, and go to `SEND` with idx 0. Otherwise go to `IDLE`.
- **Pending buffer** (one entry):
  - A `uart_en` in any state other than `IDLE` writes `pend_num` and sets `pend_v`.
  - If `pend_v` was already set, the older value is overwritten and `overrun_cnt` increments (saturating).
  - A `uart_en` in the same cycle that `GAP` consumes the pending entry: the new value becomes the pending entry (`pend_v` stays 1). No overrun is counted.
- `busy` = (state ≠ `IDLE`) OR `pend_v`, registered.
- **Byte transmitter FSM** states: `B_IDLE`, `B_START`, `B_DATA`, `B_STOP`.
  - `bit_cnt` counts 0..`CLKS_PER_BIT`-1; `bit_idx` counts 0..7.
  - `done` is a one-cycle pulse on the last cycle of the stop bit.
- `tx` is driven from a register (no combinational glitches).

## Timing
- **Reset values:** `tx`=1, `busy`=0, `overrun_cnt`=0, `pend_v`=0, both FSMs idle.
- **Reset mid-transmission:** `tx` returns high immediately (asynchronously); the partial frame and pending entry are discarded.
- **Start latency:** `uart_en` high in cycle k while `IDLE` → `tx` falls at cycle k+2 (one cycle for FSM entry, one for the registered output). `busy`=1 from k+1.
- **Message length:** 50·`CLKS_PER_BIT` cycles of framed data. Two messages sent back to back have a 2-cycle idle-high gap between the LF stop bit and the next start bit.
- **Inputs ignored while idle:** `final_number` is don't-care unless `uart_en` is high.
- **Simultaneous events:**
  - `uart_en` in the final stop-bit cycle counts as "not `IDLE`" and goes to pending.
  - `uart_en` in the `GAP` cycle is handled as defined under Operation.
- **Back-pressure:** no handshake is returned to the upstream counter. Results are latest-wins through the single pending slot.

## Structure
- **Shared package** `gesture_pkg`:
  - byte constants `ASCII_G`, `ASCII_COLON`, `ASCII_ZERO`, `ASCII_QMARK`, `ASCII_CR`, `ASCII_LF`
  - `MSG_LEN`=5
  - state enums for both FSMs
- **Sub-module** `uart_byte_tx`:
  - parameter `CLKS_PER_BIT`
  - ports `clk`, `rst_n`, `start`, `data[7:0]`, `tx`, `done`, `busy`
- The top level holds the message FSM, the pending buffer, the digit-byte mux and the overrun counter.

## Test plan
All scenarios use `CLK_FREQ`=1_000_000 and `BAUD`=100_000, so `CLKS_PER_BIT`=10.
- **Single message:** `uart_en` pulse with `final_number`=3 → decoded bytes 47 3A 33 0D 0A. First falling edge of `tx` 2 cycles after the pulse. `busy` deasserts 500 cycles after the first start bit plus 1–2 cycles.
- **Out-of-range value:** `final_number`=12 → digit byte 0x3F; other bytes unchanged.
- **Pending overwrite:** during message A (value 1), pulse value 4 then value 5 → message A, then one message carrying 0x35 after a 2-cycle gap. `overrun_cnt`=1. Value 4 is never sent.
- **Pulse on last stop-bit cycle:** `uart_en` in the last stop-bit cycle of LF → a second message follows with no loss. `overrun_cnt` unchanged.
- **Reset mid-byte:** assert `rst_n` low during the 3rd data bit of byte 2 → `tx`=1 and `busy`=0 immediately. After release, the line stays idle until the next `uart_en`.
- **Saturation:** 300 pulses while busy → `overrun_cnt` sticks at 255.

Source files
------------

// File: rtl/gesture_pkg.sv
// Shared constants, state encodings and message-byte lookup for the gesture UART path.
package gesture_pkg;

    localparam int unsigned MSG_LEN = 5;
    localparam int unsigned IDX_W   = 3;

    localparam logic [7:0] ASCII_G     = 8'h47;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } msg_state_e;

    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } byte_state_e;

    // Byte idx of the frame "G:<d>\r\n"; values above 9 print as '?'.
    function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] idx, input logic [3:0] num);
        logic [7:0] b;
        case (idx)
            3'd0:    b = ASCII_G;
            3'd1:    b = ASCII_COLON;
            3'd2:    b = (num <= 4'd9) ? ASCII_ZERO + {4'd0, num} : ASCII_QMARK;
            3'd3:    b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser; a start seen on the final stop-bit cycle chains the next byte with no idle bit.
module uart_byte_tx
    import gesture_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output logic       busy
);

    localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    byte_state_e      state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             bit_end;

    assign bit_end = (bit_cnt_q == CNT_LAST);
    assign tx      = tx_q;
    assign done    = (state_q == B_STOP) && bit_end;
    assign busy    = (state_q != B_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= B_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                B_IDLE: begin
                    bit_cnt_q <= '0;
                    if (start) begin
                        state_q <= B_START;
                        shift_q <= data;
                        tx_q    <= 1'b0;
                    end
                end
                B_START: begin
                    bit_cnt_q <= bit_end ? '0 : bit_cnt_q + CNT_W'(1);
                    if (bit_end) begin
                        state_q   <= B_DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                end
                B_DATA: begin
                    bit_cnt_q <= bit_end ? '0 : bit_cnt_q + CNT_W'(1);
                    if (bit_end) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= B_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                B_STOP: begin
                    bit_cnt_q <= bit_end ? '0 : bit_cnt_q + CNT_W'(1);
                    if (bit_end) begin
                        if (start) begin
                            state_q <= B_START;
                            shift_q <= data;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= B_IDLE;
                        end
                    end
                end
                default: state_q <= B_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gesture_uart_tx.sv
// Sends each finalised gesture count as "G:<d>\r\n" over 8N1, with a one-entry latest-wins pending slot.
module gesture_uart_tx
    import gesture_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 115_200,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_en,
    input  logic [3:0] final_number,
    output logic       tx,
    output logic       busy,
    output logic [7:0] overrun_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

    msg_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       cur_num_q;
    logic [3:0]       pend_num_q;
    logic             pend_v_q;
    logic             busy_q;
    logic [7:0]       ovr_q;

    logic             byte_done;
    logic             byte_busy;
    logic             byte_start_c;
    logic [IDX_W-1:0] sel_idx_c;
    logic [7:0]       byte_data_c;

    // On done the next byte is presented immediately so bytes inside a message are contiguous.
    assign sel_idx_c    = byte_done ? idx_q + IDX_W'(1) : idx_q;
    assign byte_start_c = (state_q == SEND) && (!byte_busy || (byte_done && idx_q != LAST_IDX));
    assign byte_data_c  = msg_byte(sel_idx_c, cur_num_q);

    assign busy        = busy_q;
    assign overrun_cnt = ovr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cur_num_q  <= '0;
            pend_num_q <= '0;
            pend_v_q   <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q <= uart_en;
                    if (uart_en) begin
                        state_q   <= SEND;
                        idx_q     <= '0;
                        cur_num_q <= final_number;
                    end
                end
                SEND: begin
                    busy_q <= 1'b1;
                    if (uart_en) begin
                        pend_num_q <= final_number;
                        pend_v_q   <= 1'b1;
                        if (pend_v_q && ovr_q != 8'hFF) begin
                            ovr_q <= ovr_q + 8'd1;
                        end
                    end
                    if (byte_done) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= GAP;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                GAP: begin
                    idx_q  <= '0;
                    busy_q <= pend_v_q || uart_en;
                    if (pend_v_q) begin
                        // A strobe landing here refills the slot just consumed; not an overrun.
                        state_q   <= SEND;
                        cur_num_q <= pend_num_q;
                        pend_v_q  <= uart_en;
                        if (uart_en) begin
                            pend_num_q <= final_number;
                        end
                    end else if (uart_en) begin
                        state_q   <= SEND;
                        cur_num_q <= final_number;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .start(byte_start_c),
        .data (byte_data_c),
        .tx   (tx),
        .done (byte_done),
        .busy (byte_busy)
    );

endmodule

// File: tb/tb_gesture_uart_tx.sv
// Directed + randomized bench for gesture_uart_tx: a line receiver decodes tx and is compared to expected frames.
module tb_gesture_uart_tx;

    localparam int unsigned CPB      = 10;
    localparam int          BYTE_CYC = 10 * CPB;
    localparam int          MSG_CYC  = 5 * BYTE_CYC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_en = 1'b0;
    logic [3:0] final_number = 4'd0;
    logic       tx;
    logic       busy;
    logic [7:0] overrun_cnt;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int falls = 0;
    int framing_err = 0;
    int exp_ovr = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] exp_q[$];

    gesture_uart_tx #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_en     (uart_en),
        .final_number(final_number),
        .tx          (tx),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge tx) falls <= falls + 1;

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    // Line receiver: detect start, sample each bit mid-period, record byte and its start cycle.
    initial begin : monitor
        logic [7:0] b;
        int         t;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                t = cyc;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) framing_err++;
                rx_q.push_back(b);
                rx_t.push_back(t);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] digit_byte(input int n);
        return (n <= 9) ? 8'(48 + n) : 8'h3F;
    endfunction

    task automatic expect_msg(input int n);
        exp_q.push_back(8'h47);
        exp_q.push_back(8'h3A);
        exp_q.push_back(digit_byte(n));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic pulse(input int n, output int k);
        @(negedge clk);
        uart_en      = 1'b1;
        final_number = 4'(n);
        k            = cyc;
        @(negedge clk);
        uart_en      = 1'b0;
        final_number = 4'($urandom);
    endtask

    task automatic wait_idle(input string tag, output int tf);
        int t0;
        t0 = cyc;
        while (busy !== 1'b0 && cyc - t0 < 5000) @(negedge clk);
        tf = cyc;
        check({tag, "_idle"}, 32'(busy), 32'd0);
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Expected frames are contiguous bytes; consecutive messages are separated by two idle cycles.
    task automatic check_rx(input string tag);
        logic [7:0] e;
        logic [7:0] b;
        int         t;
        int         tprev;
        int         j;
        j     = 0;
        tprev = 0;
        while (exp_q.size() > 0) begin
            if (rx_q.size() == 0) begin
                check({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                b = rx_q.pop_front();
                t = rx_t.pop_front();
                check({tag, "_byte"}, 32'(b), 32'(e));
                if (j > 0) check({tag, "_spacing"}, 32'(t - tprev), 32'((j % 5 == 0) ? BYTE_CYC + 2 : BYTE_CYC));
                tprev = t;
                j++;
            end
        end
        check({tag, "_extra"}, 32'(rx_q.size()), 32'd0);
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic send_one(input int n, input string tag);
        int k;
        int s;
        int tf;
        int t0;
        check({tag, "_busy_pre"}, 32'(busy), 32'd0);
        pulse(n, k);
        check({tag, "_busy_k1"}, 32'(busy), 32'd1);
        expect_msg(n);
        t0 = cyc;
        while (rx_t.size() == 0 && cyc - t0 < 4 * BYTE_CYC) @(negedge clk);
        s = (rx_t.size() > 0) ? rx_t[0] : -1000;
        check({tag, "_latency"}, 32'(s - k), 32'd2);
        wait_idle(tag, tf);
        check({tag, "_busy_fall"}, 32'((tf - s) inside {MSG_CYC + 1, MSG_CYC + 2}), 32'd1);
        check_rx(tag);
    endtask

    initial begin : stim
        int k;
        int k2;
        int s;
        int tf;
        int f0;
        int r;

        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(overrun_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_one(3, "single");
        send_one(12, "oor");
        for (int i = 0; i < 4; i++) send_one(int'($urandom_range(0, 15)), "rand");

        // Two strobes during message A: the older pending value is overwritten.
        pulse(1, k);
        expect_msg(1);
        repeat (50) @(negedge clk);
        pulse(4, k2);
        repeat (20) @(negedge clk);
        pulse(5, k2);
        expect_msg(5);
        exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
        wait_idle("pend", tf);
        check_rx("pend");
        check("pend_ovr", 32'(overrun_cnt), 32'(exp_ovr));

        // Strobe on the last stop-bit cycle of LF (start at k+2, 500 framed cycles).
        r = int'($urandom_range(0, 15));
        pulse(r, k);
        expect_msg(r);
        while (cyc < k + MSG_CYC) @(negedge clk);
        r = int'($urandom_range(0, 15));
        pulse(r, k2);
        expect_msg(r);
        wait_idle("laststop", tf);
        check_rx("laststop");
        check("laststop_ovr", 32'(overrun_cnt), 32'(exp_ovr));

        // Reset during the 3rd data bit of the second byte.
        pulse(2, k);
        s = k + 2;
        while (cyc < s + BYTE_CYC + 3 * CPB + 5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_ovr = 0;
        check("rstmid_tx", 32'(tx), 32'd1);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_ovr", 32'(overrun_cnt), 32'(exp_ovr));
        repeat (3) @(negedge clk);
        f0 = falls;
        rst_n = 1'b1;
        repeat (2 * BYTE_CYC) @(negedge clk);
        check("rstmid_quiet", 32'(falls - f0), 32'd0);
        check("rstmid_busy_after", 32'(busy), 32'd0);
        rx_q.delete();
        rx_t.delete();
        exp_q.delete();
        send_one(int'($urandom_range(0, 15)), "recover");

        // Saturation: 300 strobes while busy.
        pulse(int'($urandom_range(0, 15)), k);
        for (int i = 0; i < 100; i++) pulse(int'($urandom_range(0, 15)), k2);
        exp_ovr = exp_ovr + 99;
        check("sat_99", 32'(overrun_cnt), 32'(exp_ovr));
        for (int i = 0; i < 200; i++) pulse(int'($urandom_range(0, 15)), k2);
        exp_ovr = 255;
        check("sat_255", 32'(overrun_cnt), 32'(exp_ovr));
        wait_idle("sat", tf);
        check("sat_hold", 32'(overrun_cnt), 32'(exp_ovr));
        rx_q.delete();
        rx_t.delete();

        check("framing", 32'(framing_err), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
